// File: rtl/ahb_to_apb3_bridge_if.sv
// Bus bundle between an AHB-Lite master and an APB3 peripheral, seen through the bridge.
// The slave modport is the bridge's view; the master modport is the surrounding system.
interface ahb_to_apb3_bridge_if #(
    parameter int unsigned ADDRWIDTH = 12
);
    // AHB-Lite side
    logic                 HSEL;
    logic [ADDRWIDTH-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic [2:0]           HSIZE;
    logic                 HWRITE;
    logic                 HREADY;
    logic [31:0]          HWDATA;
    logic                 HREADYOUT;
    logic [31:0]          HRDATA;
    logic                 HRESP;
    // APB3 side
    logic                 PSEL;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [31:0]          PWDATA;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;
    logic                 APBACTIVE;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        input  PRDATA, PREADY, PSLVERR,
        output HREADYOUT, HRDATA, HRESP,
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA, APBACTIVE
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
        output PRDATA, PREADY, PSLVERR,
        input  HREADYOUT, HRDATA, HRESP,
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA, APBACTIVE
    );
endinterface

// File: rtl/ahb_to_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge. Each accepted AHB transfer becomes one APB
// SETUP/ACCESS sequence; the AHB data phase is stretched until the APB slave completes.
module ahb_to_apb3_bridge #(
    parameter int unsigned ADDRWIDTH = 12
) (
    input logic                      HCLK,
    input logic                      HRESETn,
    ahb_to_apb3_bridge_if.slave      bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StSetup,
        StAccess,
        StDone,
        StErr1,
        StErr2
    } state_e;

    state_e               state_q, state_d;
    logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [31:0]          hrdata_q, hrdata_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 accept;

    // Size, transfer-type bit 0 and byte offset carry no meaning for 32-bit APB accesses.
    logic unused_inputs;
    assign unused_inputs = ^{bus.HSIZE, bus.HTRANS[0], bus.HADDR[1:0]};

    assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

    // Next-state and datapath capture; PSEL/PENABLE are derived from the next state so they
    // come straight out of flops.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
        unique case (state_q)
            StIdle, StDone, StErr2: begin
                if (accept) begin
                    state_d  = StLatch;
                    paddr_d  = {bus.HADDR[ADDRWIDTH-1:2], 2'b00};
                    pwrite_d = bus.HWRITE;
                end else begin
                    state_d = StIdle;
                end
            end
            StLatch: begin
                // HWDATA is only valid in the AHB data phase, one cycle after the accept.
                if (pwrite_q) begin
                    pwdata_d = bus.HWDATA;
                end
                state_d = StSetup;
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                if (bus.PREADY) begin
                    if (bus.PSLVERR) begin
                        state_d = StErr1;
                    end else begin
                        if (!pwrite_q) begin
                            hrdata_d = bus.PRDATA;
                        end
                        state_d = StDone;
                    end
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
        psel_d    = (state_d == StSetup) || (state_d == StAccess);
        penable_d = (state_d == StAccess);
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= StIdle;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            hrdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            hrdata_q  <= hrdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    assign bus.HREADYOUT = !((state_q == StLatch) || (state_q == StSetup) ||
                             (state_q == StAccess) || (state_q == StErr1));
    assign bus.HRESP     = (state_q == StErr1) || (state_q == StErr2);
    assign bus.HRDATA    = hrdata_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.APBACTIVE = (state_q == StLatch) || (state_q == StSetup) ||
                           (state_q == StAccess);

endmodule

// File: doc/ahb_to_apb3_bridge.md
Name: ahb_to_apb3_bridge

Overview:
- AHB-Lite slave to APB3 master bridge.
- Converts single AHB transfers into APB3 SETUP/ACCESS cycles for one downstream APB3 peripheral, such as the APB3 example slave.
- Sits directly upstream of that slave: its APB outputs drive the slave's PSEL/PADDR/PENABLE/PWRITE/PWDATA, and it consumes the slave's PRDATA/PREADY/PSLVERR.
- Single clock domain; the APB clock equals HCLK.

Parameters:
ADDRWIDTH, 12, width of HADDR and PADDR; PADDR[1:0] always 2'b00

Ports:
HCLK  input  1  bus clock (APB side also runs on this clock)
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  AHB slave select
HADDR  input  ADDRWIDTH  AHB address
HTRANS  input  2  AHB transfer type; only HTRANS[1] is used
HSIZE  input  3  ignored; all accesses are 32-bit
HWRITE  input  1  AHB direction
HREADY  input  1  AHB bus ready (previous transfer complete)
HWDATA  input  32  AHB write data, valid in the data phase
HREADYOUT  output  1  slave ready
HRDATA  output  32  read data
HRESP  output  1  0=OKAY, 1=ERROR
PSEL  output  1  APB select
PADDR  output  ADDRWIDTH  APB address
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PWDATA  output  32  APB write data
PRDATA  input  32  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB error, valid only when PREADY=1
APBACTIVE  output  1  high while an APB transfer is in progress; for peripheral clock gating

Behaviour:
- Reset: clock = HCLK; reset is asynchronous, active-low (HRESETn).
  - Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, APBACTIVE=0.
  - Reset asserted mid-transfer aborts immediately; outputs return to reset values without waiting for a clock edge.
- Accept condition: HSEL & HTRANS[1] & HREADY, in state IDLE, DONE or ERR2.
  - On accept: register {HADDR[ADDRWIDTH-1:2],2'b00} into PADDR, register HWRITE into PWRITE, go to LATCH.
  - If not accepted from DONE or ERR2, go to IDLE.
- States and outputs:
  - IDLE: HREADYOUT=1, HRESP=0.
  - LATCH: HREADYOUT=0. If PWRITE, capture HWDATA into PWDATA. Next state SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. Next state ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0.
    - PREADY=0: stay in ACCESS with PADDR, PWRITE, PWDATA held stable.
    - PREADY=1 & PSLVERR=0: if read, capture PRDATA into HRDATA; go to DONE.
    - PREADY=1 & PSLVERR=1: go to ERR1; HRDATA is not updated.
  - DONE: HREADYOUT=1, HRESP=0; HRDATA holds the captured value.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1 (AHB two-cycle error response).
- PSEL and PENABLE are registered outputs and are 0 in every state except SETUP and ACCESS.
- PADDR, PWRITE and PWDATA hold their last values after a transfer completes.
- Latency with PREADY tied high: accept at edge T; HREADYOUT=0 during cycles T+1..T+3 (LATCH, SETUP, ACCESS); HREADYOUT=1 at T+4. That is 3 wait states; each PREADY=0 cycle adds one.
- Back-to-back transfers: a transfer accepted in DONE or ERR2 goes straight to LATCH, with no IDLE cycle in between.
- APBACTIVE=1 in LATCH, SETUP and ACCESS.
- HTRANS=BUSY or IDLE, and HSEL=0, are ignored; HREADYOUT stays 1 and HRESP 0.
- HSIZE, and HADDR[1:0], are ignored; no byte strobes are generated.
- PSLVERR is ignored while PREADY=0.

Test Plan:
- Write 0xA5A5_1234 to HADDR=0x010 with PREADY=1 → PSEL rises at T+2; PENABLE=1 at T+3 with PADDR=0x010, PWRITE=1, PWDATA=0xA5A5_1234; HREADYOUT=1, HRESP=0 at T+4.
- Read HADDR=0x3FE with PRDATA=0x0000_CAFE → PADDR=0x3FC; HRDATA=0x0000_CAFE and HREADYOUT=1 at T+4.
- Read with PREADY held low 3 cycles in ACCESS → PSEL=PENABLE=1 held; PADDR stable; HREADYOUT low for 6 cycles total; HRDATA updated only when PREADY=1.
- Write completing with PREADY=1 & PSLVERR=1 → ERR1 cycle (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then IDLE with HRESP=0.
- Back-to-back write 0x004 then read 0x008, second accepted in DONE → second SETUP starts 2 cycles after DONE; PSEL deasserted exactly 2 cycles between the transfers (DONE and LATCH).
- HRESETn pulsed low during ACCESS → PSEL, PENABLE and APBACTIVE fall asynchronously; HREADYOUT=1; after release, an IDLE HTRANS leaves all APB outputs at 0.
